// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the cache-line memory port arbiter: FSM states,
// requester IDs and the line-offset helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_I   = 2'd1,
    ST_GNT_D   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int LINE_OFF_BITS = 5;

  // Number of byte-offset bits inside one cache line of clsize bits.
  function automatic int line_off_bits(input int clsize);
    return $clog2(clsize / 32'sd8);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-controller side bus of the arbiter: one line-sized request/ready
// handshake. master = arbiter, slave = memory controller.
interface mem_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 256
);
  logic              m_strobe_o;
  logic              m_rw_o;
  logic [XLEN-1:0]   m_addr_o;
  logic [CLSIZE-1:0] m_data_o;
  logic              m_ready_i;
  logic [CLSIZE-1:0] m_data_i;

  modport master (
    output m_strobe_o, m_rw_o, m_addr_o, m_data_o,
    input  m_ready_i, m_data_i
  );

  modport slave (
    input  m_strobe_o, m_rw_o, m_addr_o, m_data_o,
    output m_ready_i, m_data_i
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational tie-break between the I-cache and D-cache strobes; on a tie
// the requester named by the priority pointer wins.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_e prio,
  output req_id_e winner,
  output logic    valid
);

  // Winner selection: a lone requester always wins, ties go to the pointer.
  always_comb begin
    winner = REQ_D;
    valid  = i_req | d_req;
    if (i_req && d_req) begin
      winner = prio;
    end else if (i_req) begin
      winner = REQ_I;
    end else begin
      winner = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single cache-line memory port between I-cache and D-cache.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is D-cache priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_strobe_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic              i_ready_o,
  output logic [CLSIZE-1:0] i_data_o,
  input  logic              d_strobe_i,
  input  logic              d_rw_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [CLSIZE-1:0] d_data_i,
  output logic              d_ready_o,
  output logic [CLSIZE-1:0] d_data_o,
  mem_port_arbiter_if.master mem
);

  localparam int              OFF_BITS  = line_off_bits(CLSIZE);
  localparam logic [XLEN-1:0] ADDR_MASK = {XLEN{1'b1}} << OFF_BITS;

  arb_state_e        state_r;
  logic              m_strobe_r;
  logic              m_rw_r;
  logic [XLEN-1:0]   m_addr_r;
  logic [CLSIZE-1:0] m_data_r;
  req_id_e           prio_s;
  req_id_e           pick_winner_s;
  logic              pick_valid_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e           prio_r;
  assign prio_s = prio_r;
`else
  assign prio_s = REQ_D;
`endif

  mem_arb_pick u_pick (
    .i_req  (i_strobe_i),
    .d_req  (d_strobe_i),
    .prio   (prio_s),
    .winner (pick_winner_s),
    .valid  (pick_valid_s)
  );

  // Transaction FSM with registered memory-side request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      m_strobe_r <= 1'b0;
      m_rw_r     <= 1'b0;
      m_addr_r   <= {XLEN{1'b0}};
      m_data_r   <= {CLSIZE{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_r     <= REQ_D;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            m_strobe_r <= 1'b1;
            if (pick_winner_s == REQ_D) begin
              m_rw_r   <= d_rw_i;
              m_addr_r <= d_addr_i & ADDR_MASK;
              m_data_r <= d_data_i;
              state_r  <= ST_GNT_D;
            end else begin
              m_rw_r   <= 1'b0;
              m_addr_r <= i_addr_i & ADDR_MASK;
              m_data_r <= {CLSIZE{1'b0}};
              state_r  <= ST_GNT_I;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_r <= (pick_winner_s == REQ_D) ? REQ_I : REQ_D;
`endif
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (mem.m_ready_i) begin
            m_strobe_r <= 1'b0;
            state_r    <= ST_RELEASE;
          end
        end
        // Strobes are ignored here: requesters may still show a stale 1.
        ST_RELEASE: state_r <= ST_IDLE;
        default:    state_r <= ST_IDLE;
      endcase
    end
  end

  assign mem.m_strobe_o = m_strobe_r;
  assign mem.m_rw_o     = m_rw_r;
  assign mem.m_addr_o   = m_addr_r;
  assign mem.m_data_o   = m_data_r;

  assign i_ready_o = mem.m_ready_i & (state_r == ST_GNT_I);
  assign d_ready_o = mem.m_ready_i & (state_r == ST_GNT_D);
  assign i_data_o  = mem.m_data_i;
  assign d_data_o  = mem.m_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and
// outputs are sampled around the falling clock edge.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int XLEN   = 32;
  localparam int CLSIZE = 256;

  logic              clk;
  logic              rst;
  logic              i_strobe;
  logic [XLEN-1:0]   i_addr;
  logic              i_ready;
  logic [CLSIZE-1:0] i_data;
  logic              d_strobe;
  logic              d_rw;
  logic [XLEN-1:0]   d_addr;
  logic [CLSIZE-1:0] d_wdata;
  logic              d_ready;
  logic [CLSIZE-1:0] d_data;

  int errors;
  int checks;

  mem_port_arbiter_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) mem_bus ();

  mem_port_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .i_strobe_i (i_strobe),
    .i_addr_i   (i_addr),
    .i_ready_o  (i_ready),
    .i_data_o   (i_data),
    .d_strobe_i (d_strobe),
    .d_rw_i     (d_rw),
    .d_addr_i   (d_addr),
    .d_data_i   (d_wdata),
    .d_ready_o  (d_ready),
    .d_data_o   (d_data),
    .mem        (mem_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_strobe = 1'b0;
    d_strobe = 1'b0;
    mem_bus.m_ready_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mem_bus.m_strobe_o !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", mem_bus.m_strobe_o); end
    checks++;
    if ({mem_bus.m_rw_o, mem_bus.m_addr_o} !== 33'h0) begin errors++; $display("FAIL reset_rw_addr got %h exp 0", {mem_bus.m_rw_o, mem_bus.m_addr_o}); end
    checks++;
    if (mem_bus.m_data_o !== {CLSIZE{1'b0}}) begin errors++; $display("FAIL reset_data got %h exp 0", mem_bus.m_data_o); end
    checks++;
    if ({i_ready, d_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {i_ready, d_ready}); end
    checks++;
    if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_r, ST_IDLE); end
  endtask

  task automatic test_icache_only();
    logic [CLSIZE-1:0] fill;
    fill = {8{32'hC0DE_0001}};
    do_reset();
    i_strobe = 1'b1;
    i_addr   = 32'h0000_1234;
    tick();
    checks++;
    if (mem_bus.m_strobe_o !== 1'b1) begin errors++; $display("FAIL i_grant_strobe got %b exp 1", mem_bus.m_strobe_o); end
    checks++;
    if (mem_bus.m_addr_o !== 32'h0000_1220) begin errors++; $display("FAIL i_grant_addr got %h exp 00001220", mem_bus.m_addr_o); end
    checks++;
    if (mem_bus.m_rw_o !== 1'b0) begin errors++; $display("FAIL i_grant_rw got %b exp 0", mem_bus.m_rw_o); end
    checks++;
    if (mem_bus.m_data_o !== {CLSIZE{1'b0}}) begin errors++; $display("FAIL i_grant_data got %h exp 0", mem_bus.m_data_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({mem_bus.m_strobe_o, i_ready, d_ready} !== 3'b100) begin errors++; $display("FAIL i_wait_%0d got %b exp 100", k, {mem_bus.m_strobe_o, i_ready, d_ready}); end
    end
    mem_bus.m_ready_i = 1'b1;
    mem_bus.m_data_i  = fill;
    #1;
    checks++;
    if ({i_ready, d_ready} !== 2'b10) begin errors++; $display("FAIL i_ready_pulse got %b exp 10", {i_ready, d_ready}); end
    checks++;
    if (i_data !== fill) begin errors++; $display("FAIL i_fill_data got %h exp %h", i_data, fill); end
    tick();
    mem_bus.m_ready_i = 1'b0;
    #1;
    checks++;
    if ({mem_bus.m_strobe_o, i_ready, d_ready} !== 3'b000) begin errors++; $display("FAIL i_release got %b exp 000", {mem_bus.m_strobe_o, i_ready, d_ready}); end
    // Stale strobe stays high through RELEASE, then drops.
    tick();
    i_strobe = 1'b0;
    tick();
    checks++;
    if (mem_bus.m_strobe_o !== 1'b0) begin errors++; $display("FAIL stale_no_request got %b exp 0", mem_bus.m_strobe_o); end
    checks++;
    if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL stale_state got %0d exp %0d", dut.state_r, ST_IDLE); end
  endtask

  task automatic test_tie_d_first();
    logic [CLSIZE-1:0] wb;
    wb = {8{32'hBEEF_0D0D}};
    do_reset();
    i_strobe = 1'b1;
    i_addr   = 32'h2000_0100;
    d_strobe = 1'b1;
    d_rw     = 1'b1;
    d_addr   = 32'h8000_0040;
    d_wdata  = wb;
    tick();
    checks++;
    if ({mem_bus.m_strobe_o, mem_bus.m_rw_o} !== 2'b11) begin errors++; $display("FAIL tie_d_strobe_rw got %b exp 11", {mem_bus.m_strobe_o, mem_bus.m_rw_o}); end
    checks++;
    if (mem_bus.m_addr_o !== 32'h8000_0040) begin errors++; $display("FAIL tie_d_addr got %h exp 80000040", mem_bus.m_addr_o); end
    checks++;
    if (mem_bus.m_data_o !== wb) begin errors++; $display("FAIL tie_d_data got %h exp %h", mem_bus.m_data_o, wb); end
    tick();
    mem_bus.m_ready_i = 1'b1;
    #1;
    checks++;
    if ({i_ready, d_ready} !== 2'b01) begin errors++; $display("FAIL tie_d_ready got %b exp 01", {i_ready, d_ready}); end
    tick();
    mem_bus.m_ready_i = 1'b0;
    checks++;
    if (mem_bus.m_strobe_o !== 1'b0) begin errors++; $display("FAIL tie_release_strobe got %b exp 0", mem_bus.m_strobe_o); end
    tick();
    d_strobe = 1'b0;
    checks++;
    if (mem_bus.m_strobe_o !== 1'b0) begin errors++; $display("FAIL tie_idle_strobe got %b exp 0", mem_bus.m_strobe_o); end
    tick();
    checks++;
    if ({mem_bus.m_strobe_o, mem_bus.m_rw_o} !== 2'b10) begin errors++; $display("FAIL tie_i_grant got %b exp 10", {mem_bus.m_strobe_o, mem_bus.m_rw_o}); end
    checks++;
    if (mem_bus.m_addr_o !== 32'h2000_0100) begin errors++; $display("FAIL tie_i_addr got %h exp 20000100", mem_bus.m_addr_o); end
    mem_bus.m_ready_i = 1'b1;
    #1;
    checks++;
    if ({i_ready, d_ready} !== 2'b10) begin errors++; $display("FAIL tie_i_ready got %b exp 10", {i_ready, d_ready}); end
    tick();
    mem_bus.m_ready_i = 1'b0;
    i_strobe = 1'b0;
  endtask

  task automatic test_back_to_back();
    req_id_e exp_order [4];
    req_id_e got;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{REQ_D, REQ_I, REQ_D, REQ_I};
`else
    exp_order = '{REQ_D, REQ_D, REQ_D, REQ_D};
`endif
    do_reset();
    i_strobe = 1'b1;
    i_addr   = 32'h0000_3000;
    d_strobe = 1'b1;
    d_rw     = 1'b0;
    d_addr   = 32'h0000_5000;
    for (int k = 0; k < 4; k++) begin
      tick();
      got = (mem_bus.m_addr_o == 32'h0000_5000) ? REQ_D : REQ_I;
      checks++;
      if (mem_bus.m_strobe_o !== 1'b1 || got !== exp_order[k]) begin errors++; $display("FAIL b2b_grant_%0d got strobe=%b id=%0d exp strobe=1 id=%0d", k, mem_bus.m_strobe_o, got, exp_order[k]); end
      mem_bus.m_ready_i = 1'b1;
      #1;
      checks++;
      if ({i_ready, d_ready} !== ((exp_order[k] == REQ_D) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL b2b_ready_%0d got %b", k, {i_ready, d_ready}); end
      tick();
      mem_bus.m_ready_i = 1'b0;
      tick();
    end
    i_strobe = 1'b0;
    d_strobe = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_strobe = 1'b1;
    d_rw     = 1'b1;
    d_addr   = 32'h8000_0040;
    d_wdata  = {8{32'h1234_5678}};
    tick();
    checks++;
    if (mem_bus.m_strobe_o !== 1'b1) begin errors++; $display("FAIL mid_pre_strobe got %b exp 1", mem_bus.m_strobe_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_strobe = 1'b0;
    checks++;
    if ({mem_bus.m_strobe_o, mem_bus.m_rw_o, mem_bus.m_addr_o} !== 34'h0) begin errors++; $display("FAIL mid_reset_outputs got %h exp 0", {mem_bus.m_strobe_o, mem_bus.m_rw_o, mem_bus.m_addr_o}); end
    checks++;
    if (mem_bus.m_data_o !== {CLSIZE{1'b0}}) begin errors++; $display("FAIL mid_reset_data got %h exp 0", mem_bus.m_data_o); end
    checks++;
    if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL mid_reset_state got %0d exp %0d", dut.state_r, ST_IDLE); end
    mem_bus.m_ready_i = 1'b1;
    #1;
    checks++;
    if ({i_ready, d_ready} !== 2'b00) begin errors++; $display("FAIL mid_spurious_ready got %b exp 00", {i_ready, d_ready}); end
    tick();
    mem_bus.m_ready_i = 1'b0;
  endtask

  task automatic test_idle_ready();
    do_reset();
    mem_bus.m_ready_i = 1'b1;
    #1;
    checks++;
    if ({i_ready, d_ready} !== 2'b00) begin errors++; $display("FAIL idle_ready got %b exp 00", {i_ready, d_ready}); end
    tick();
    mem_bus.m_ready_i = 1'b0;
    checks++;
    if (dut.state_r !== ST_IDLE || mem_bus.m_strobe_o !== 1'b0) begin errors++; $display("FAIL idle_state got state=%0d strobe=%b exp state=0 strobe=0", dut.state_r, mem_bus.m_strobe_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    i_strobe = 1'b0;
    i_addr = 32'h0;
    d_strobe = 1'b0;
    d_rw = 1'b0;
    d_addr = 32'h0;
    d_wdata = {CLSIZE{1'b0}};
    mem_bus.m_ready_i = 1'b0;
    mem_bus.m_data_i = {CLSIZE{1'b0}};
    tick();
    test_reset();
    test_icache_only();
    test_tie_d_first();
    test_back_to_back();
    test_reset_mid();
    test_idle_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
